// File: rtl/uart_pkg.sv
// uart_pkg: shared state encoding, default parameters and vote-tick helper for the UART receiver
package uart_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, RECOVER} state_e;
  localparam int OVERSAMPLE_DEF = 16;
  localparam int DATA_BITS_DEF = 8;
  function automatic int vote_tick(input int oversample, input int offset);
    return oversample / 2 + offset;
  endfunction
endpackage

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: two-flop synchronizer with a configurable reset value
module uart_rx_sync #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic [1:0] ff_q, ff_d;
  assign ff_d = {ff_q[0], d};
  assign q = ff_q[1];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) ff_q <= {2{RST_VAL}};
    else ff_q <= ff_d;
endmodule

// File: rtl/uart_rx.sv
// uart_rx: oversampled UART receiver with 3-sample majority vote and valid/ack byte output
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_BITS = DATA_BITS_DEF,
  parameter int OVERSAMPLE = OVERSAMPLE_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx,
  input  logic                 baud16_en,
  input  logic                 rx_ack,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 frame_err,
  output logic                 overrun_err,
  output logic                 rx_busy
);
  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [TW-1:0] T_LO = TW'(vote_tick(OVERSAMPLE, -1));
  localparam logic [TW-1:0] T_MID = TW'(vote_tick(OVERSAMPLE, 0));
  localparam logic [TW-1:0] T_HI = TW'(vote_tick(OVERSAMPLE, 1));
  localparam logic [TW-1:0] T_END = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);
  state_e state_q, state_d;
  logic [TW-1:0] tick_q, tick_d;
  logic [BW-1:0] bit_q, bit_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d, rx_data_q, rx_data_d;
  logic [1:0] samp_q, samp_d;
  logic rx_valid_q, rx_valid_d, frame_err_q, frame_err_d;
  logic overrun_err_q, overrun_err_d, rx_busy_q, rx_busy_d;
  logic rx_s, vote, at_vote, at_end, done;
  uart_rx_sync #(.RST_VAL(1'b1)) u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (rx),
    .q    (rx_s)
  );
  assign vote = (samp_q[0] & samp_q[1]) | (samp_q[0] & rx_s) | (samp_q[1] & rx_s);
  assign at_vote = baud16_en && tick_q == T_HI;
  assign at_end = baud16_en && tick_q == T_END;
  assign done = state_q == STOP && at_vote && vote;
  always_comb begin
    state_d = state_q;
    tick_d = tick_q;
    bit_d = bit_q;
    shreg_d = shreg_q;
    samp_d = samp_q;
    if (baud16_en) begin
      tick_d = at_end ? '0 : tick_q + TW'(1);
      if (tick_q == T_LO) samp_d[0] = rx_s;
      if (tick_q == T_MID) samp_d[1] = rx_s;
    end
    case (state_q)
      IDLE: state_d = (baud16_en && !rx_s) ? START : IDLE;
      START: begin
        if (at_vote && vote) state_d = IDLE;
        else if (at_end) begin
          state_d = DATA;
          bit_d = '0;
        end
      end
      DATA: begin
        if (at_vote) shreg_d = {vote, shreg_q[DATA_BITS-1:1]};
        if (at_end) begin
          if (bit_q == B_LAST) state_d = STOP;
          else bit_d = bit_q + BW'(1);
        end
      end
      STOP: state_d = at_vote ? (vote ? IDLE : RECOVER) : STOP;
      RECOVER: state_d = (baud16_en && rx_s) ? IDLE : RECOVER;
      default: state_d = IDLE;
    endcase
    if (state_d != state_q) tick_d = '0;
  end
  // a completed byte only replaces the held one if the consumer has it or is taking it now
  assign rx_valid_d = done | (rx_valid_q & ~rx_ack);
  assign rx_data_d = (done && (!rx_valid_q || rx_ack)) ? shreg_q : rx_data_q;
  assign overrun_err_d = done & rx_valid_q & ~rx_ack;
  assign frame_err_d = state_q == STOP && at_vote && !vote;
  assign rx_busy_d = state_d != IDLE;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      tick_q <= '0;
      bit_q <= '0;
      shreg_q <= '0;
      samp_q <= '0;
      rx_data_q <= '0;
      rx_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_err_q <= 1'b0;
      rx_busy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      tick_q <= tick_d;
      bit_q <= bit_d;
      shreg_q <= shreg_d;
      samp_q <= samp_d;
      rx_data_q <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      frame_err_q <= frame_err_d;
      overrun_err_q <= overrun_err_d;
      rx_busy_q <= rx_busy_d;
    end
  assign rx_data = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign frame_err = frame_err_q;
  assign overrun_err = overrun_err_q;
  assign rx_busy = rx_busy_q;
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: scoreboard bench; a serial transmitter model pushes expected byte/error events, a monitor pops them
module tb_uart_rx;
  localparam int BIT_CLK = 64;
  localparam int K_BYTE = 0;
  localparam int K_FERR = 1;
  localparam int K_OVR = 2;
  typedef struct {
    int kind;
    logic [7:0] data;
  } exp_t;
  logic clk = 1'b0, rst_n = 1'b0, rx = 1'b1, baud16_en = 1'b0, rx_ack = 1'b0;
  logic [7:0] rx_data;
  logic rx_valid, frame_err, overrun_err, rx_busy;
  exp_t exp_q[$];
  int n_cmp = 0, n_bad = 0;
  logic m_valid = 1'b0;
  logic [7:0] m_data = '0;
  uart_rx dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx         (rx),
    .baud16_en  (baud16_en),
    .rx_ack     (rx_ack),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .frame_err  (frame_err),
    .overrun_err(overrun_err),
    .rx_busy    (rx_busy)
  );
  always #5 clk = ~clk;
  initial begin
    logic [1:0] bcnt;
    bcnt = '0;
    forever begin
      @(negedge clk);
      bcnt = bcnt + 2'd1;
      baud16_en = bcnt == 2'd0;
    end
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask
  task automatic push(input int kind, input logic [7:0] data);
    exp_t e;
    e.kind = kind;
    e.data = data;
    exp_q.push_back(e);
  endtask
  task automatic got(input int kind);
    exp_t e;
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL unexpected_event: got kind %0d data 0x%0h, expected none", kind, rx_data);
    end else begin
      e = exp_q.pop_front();
      chk("event_kind", kind, e.kind);
      if (kind != K_FERR && e.kind == kind) chk("event_data", rx_data, e.data);
    end
  endtask
  initial begin
    logic pv;
    logic [7:0] pd;
    pv = 1'b0;
    pd = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pv = 1'b0;
        pd = '0;
      end else begin
        if (rx_valid && (!pv || rx_data != pd)) got(K_BYTE);
        if (frame_err) got(K_FERR);
        if (overrun_err) got(K_OVR);
        pv = rx_valid;
        pd = rx_data;
      end
    end
  end
  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic align_tick();
    do @(posedge clk); while (!baud16_en);
    #1;
  endtask
  task automatic pulse_ack();
    rx_ack = 1'b1;
    wait_clk(1);
    rx_ack = 1'b0;
    m_valid = 1'b0;
  endtask
  // Reference: frame outcome from the handshake rules; stop-vote lands 43 clocks into the stop bit when tick-aligned
  task automatic send_frame(input logic [7:0] d, input logic stop, input bit align, input bit ack_first,
                            input bit ack_vote, input int abort_bit);
    logic [9:0] fr;
    fr = {stop, d, 1'b0};
    if (align) align_tick();
    if (ack_first) m_valid = 1'b0;
    if (abort_bit < 0) begin
      if (!stop) push(K_FERR, 8'h00);
      else if (!m_valid || ack_vote) begin
        push(K_BYTE, d);
        m_valid = 1'b1;
        m_data = d;
      end else push(K_OVR, m_data);
    end
    for (int j = 0; j < 10; j++) begin
      rx = fr[j];
      if (j == abort_bit) begin
        wait_clk(BIT_CLK / 2);
        rst_n = 1'b0;
        #2;
        chk("midreset_valid", rx_valid, 0);
        chk("midreset_data", rx_data, 0);
        chk("midreset_busy", rx_busy, 0);
        chk("midreset_errs", {frame_err, overrun_err}, 0);
        rx = 1'b1;
        wait_clk(4);
        rst_n = 1'b1;
        m_valid = 1'b0;
        return;
      end
      if (j == 0 && ack_first) begin
        rx_ack = 1'b1;
        wait_clk(1);
        rx_ack = 1'b0;
        wait_clk(BIT_CLK - 1);
      end else if (j == 9 && ack_vote) begin
        wait_clk(43);
        rx_ack = 1'b1;
        wait_clk(1);
        rx_ack = 1'b0;
        wait_clk(BIT_CLK - 44);
      end else wait_clk(BIT_CLK);
    end
  endtask
  initial begin
    wait_clk(5);
    chk("reset_valid", rx_valid, 0);
    chk("reset_data", rx_data, 0);
    chk("reset_busy", rx_busy, 0);
    chk("reset_errs", {frame_err, overrun_err}, 0);
    rst_n = 1'b1;
    wait_clk(40);
    send_frame(8'hA5, 1'b1, 1, 0, 0, -1);
    wait_clk(200);
    chk("single_valid_held", rx_valid, 1);
    chk("single_data", rx_data, 8'hA5);
    pulse_ack();
    wait_clk(2);
    chk("single_ack_clears", rx_valid, 0);
    send_frame(8'h00, 1'b1, 1, 0, 0, -1);
    send_frame(8'hFF, 1'b1, 0, 1, 0, -1);
    send_frame(8'h3C, 1'b1, 0, 1, 0, -1);
    pulse_ack();
    align_tick();
    rx = 1'b0;
    wait_clk(16);
    rx = 1'b1;
    wait_clk(2 * BIT_CLK);
    chk("glitch_idle", rx_busy, 0);
    chk("glitch_no_valid", rx_valid, 0);
    send_frame(8'h55, 1'b0, 1, 0, 0, -1);
    wait_clk(20 * BIT_CLK);
    chk("break_recover_busy", rx_busy, 1);
    rx = 1'b1;
    wait_clk(2 * BIT_CLK);
    chk("break_released_idle", rx_busy, 0);
    send_frame(8'h12, 1'b1, 1, 0, 0, -1);
    pulse_ack();
    send_frame(8'h11, 1'b1, 1, 0, 0, -1);
    send_frame(8'h22, 1'b1, 1, 0, 0, -1);
    wait_clk(8);
    chk("overrun_keeps_data", rx_data, 8'h11);
    send_frame(8'h22, 1'b1, 1, 0, 1, -1);
    wait_clk(8);
    chk("ack_at_completion_data", rx_data, 8'h22);
    send_frame(8'h99, 1'b1, 1, 0, 0, 5);
    wait_clk(BIT_CLK);
    send_frame(8'h7E, 1'b1, 1, 0, 0, -1);
    pulse_ack();
    for (int i = 0; i < 30; i++) begin
      wait_clk($urandom_range(0, 100));
      send_frame(8'($urandom), 1'b1, $urandom_range(0, 1) == 1, $urandom_range(0, 2) != 0, 0, -1);
    end
    for (int i = 0; i < 2000 && exp_q.size() != 0; i++) wait_clk(1);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
